// File: rtl/native_mem_responder_if.sv
// Valid-ready native memory bus: request channel towards memory, update
// channel carrying read lines back, plus the illegal-op pulse.
interface native_mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
);
    logic                  nat_request_valid;
    logic                  nat_request_ready;
    logic [1:0]            nat_request_op;
    logic [ADDR_WIDTH-1:0] nat_request_addr;
    logic [DATA_WIDTH-1:0] nat_request_data;
    logic                  nat_update_valid;
    logic                  nat_update_ready;
    logic [DATA_WIDTH-1:0] nat_update_data;
    logic                  illegal_op;

    modport master (
        output nat_request_valid, nat_request_op, nat_request_addr,
               nat_request_data, nat_update_ready,
        input  nat_request_ready, nat_update_valid, nat_update_data, illegal_op
    );

    modport slave (
        input  nat_request_valid, nat_request_op, nat_request_addr,
               nat_request_data, nat_update_ready,
        output nat_request_ready, nat_update_valid, nat_update_data, illegal_op
    );
endinterface

// File: rtl/native_mem_responder.sv
// Memory-side responder for the native bus: line-wide storage, fixed-latency
// read pipeline and a credit-guarded response FIFO that never overflows.
module native_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 256,
    parameter int DEPTH_LINES  = 1024,
    parameter int READ_LATENCY = 4,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    native_mem_responder_if.slave nat
);
    localparam int OFS  = $clog2(DATA_WIDTH / 8);
    localparam int IDXW = $clog2(DEPTH_LINES);
    localparam int CW   = $clog2(RESP_DEPTH + 1);
    localparam int PW   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef enum logic {ST_OPEN, ST_FULL} state_e;

    state_e                state_q;
    logic [CW-1:0]         credit_q;
    logic [CW-1:0]         credit_d;
    logic                  illegal_q;
    logic                  req_acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ill_acc;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDXW-1:0]       idx;
    logic                  unused_addr;

    logic [DATA_WIDTH-1:0] mem [DEPTH_LINES];

    logic                  push_valid;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;

    // Only the line-index bits select storage; the rest alias by design.
    assign addr        = nat.nat_request_addr;
    assign idx         = addr[OFS +: IDXW];
    assign unused_addr = ^addr;

    assign nat.nat_request_ready = (state_q == ST_OPEN);
    assign req_acc  = nat.nat_request_valid & nat.nat_request_ready;
    assign wr_acc   = req_acc & (nat.nat_request_op == 2'b10);
    assign rd_acc   = req_acc & (nat.nat_request_op == 2'b01);
    assign ill_acc  = req_acc & ~(nat.nat_request_op == 2'b10) & ~(nat.nat_request_op == 2'b01);
    assign pop      = nat.nat_update_valid & nat.nat_update_ready;
    assign credit_d = credit_q + CW'(rd_acc) - CW'(pop);
    assign nat.illegal_op = illegal_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_OPEN;
            credit_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            credit_q  <= credit_d;
            illegal_q <= ill_acc;
            case (state_q)
                ST_OPEN: if (rd_acc && !pop && credit_q == CW'(RESP_DEPTH - 1)) state_q <= ST_FULL;
                ST_FULL: if (pop) state_q <= ST_OPEN;
                default: state_q <= ST_OPEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[idx] <= nat.nat_request_data;
    end

    // Latency L: a first register captures the storage read, L-2 more stages
    // follow, and the FIFO push adds the final cycle.
    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign push_valid = rd_acc;
            assign push_data  = mem[idx];
        end else begin : g_pipe
            localparam int NSTG = READ_LATENCY - 1;
            logic                  vld_q [NSTG];
            logic [DATA_WIDTH-1:0] dat_q [NSTG];

            for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk) begin
                        if (!resetn) vld_q[0] <= 1'b0;
                        else         vld_q[0] <= rd_acc;
                        if (rd_acc) dat_q[0] <= mem[idx];
                    end
                end else begin : g_tail
                    always_ff @(posedge clk) begin
                        if (!resetn) vld_q[gi] <= 1'b0;
                        else         vld_q[gi] <= vld_q[gi-1];
                        dat_q[gi] <= dat_q[gi-1];
                    end
                end
            end

            assign push_valid = vld_q[NSTG-1];
            assign push_data  = dat_q[NSTG-1];
        end
    endgenerate

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign nat.nat_update_valid = (count_q != '0);
    assign nat.nat_update_data  = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_valid) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)        rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push_valid) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_valid) fifo_mem[wr_ptr_q] <= push_data;
    end
endmodule

// File: tb/tb_native_mem_responder.sv
// Directed bench for native_mem_responder: latency, aliasing, back-pressure,
// illegal ops and mid-flight reset, all against hand-computed expectations.
module tb_native_mem_responder;
    localparam int AW = 32;
    localparam int DW = 256;
    localparam logic [1:0] OP_WR = 2'b10;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [1:0] OP_IL = 2'b11;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] d_a5, d1, d2, d3, d_11;

    native_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    native_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LINES(1024),
        .READ_LATENCY(4), .RESP_DEPTH(4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .nat    (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one request and hold it until accepted (bounded).
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        bus.nat_request_valid = 1'b1;
        bus.nat_request_op    = op;
        bus.nat_request_addr  = addr;
        bus.nat_request_data  = data;
        while (!bus.nat_request_ready && n < 50) begin
            step();
            n++;
        end
        check_val("req_ready", bus.nat_request_ready, 1);
        step();
        bus.nat_request_valid = 1'b0;
    endtask

    // Wait for the next response, compare it and pop it.
    task automatic expect_update(input string tag, input logic [DW-1:0] exp);
        int n = 0;
        bus.nat_update_ready = 1'b1;
        while (!bus.nat_update_valid && n < 40) begin
            step();
            n++;
        end
        check_val("upd_present", bus.nat_update_valid, 1);
        check_val(tag, bus.nat_update_data, exp);
        step();
    endtask

    initial begin
        bit seen;
        d_a5 = {32{8'hA5}};
        d1   = {8{32'hD1D1_0001}};
        d2   = {8{32'hD2D2_0002}};
        d3   = {8{32'hD3D3_0003}};
        d_11 = {32{8'h11}};
        bus.nat_request_valid = 1'b0;
        bus.nat_request_op    = 2'b00;
        bus.nat_request_addr  = '0;
        bus.nat_request_data  = '0;
        bus.nat_update_ready  = 1'b1;

        // Reset state
        repeat (3) step();
        check_val("rst_upd_valid", bus.nat_update_valid, 0);
        check_val("rst_illegal", bus.illegal_op, 0);
        resetn = 1'b1;
        step();
        check_val("rst_ready", bus.nat_request_ready, 1);

        // 1: write then read next cycle, exact latency
        issue(OP_WR, 32'h40, d_a5);
        check_val("wr_no_upd", bus.nat_update_valid, 0);
        issue(OP_RD, 32'h40, '0);
        for (int k = 1; k <= 3; k++) begin
            check_val("lat_low", bus.nat_update_valid, 0);
            step();
        end
        check_val("lat_hit", bus.nat_update_valid, 1);
        check_val("lat_data", bus.nat_update_data, d_a5);
        step();
        check_val("lat_popped", bus.nat_update_valid, 0);

        // 2: low offset bits ignored, upper bits alias
        issue(OP_WR, 32'h20, d1);
        issue(OP_RD, 32'h3F, '0);
        expect_update("ofs_ignored", d1);
        issue(OP_WR, 32'h8000, d2);
        issue(OP_RD, 32'h0, '0);
        expect_update("alias_wrap", d2);
        issue(OP_WR, 32'h60, d3);

        // 3+4: fill credits, hold a fifth read, pop/offer collision
        bus.nat_update_ready = 1'b0;
        issue(OP_RD, 32'h00, '0);
        issue(OP_RD, 32'h20, '0);
        issue(OP_RD, 32'h40, '0);
        issue(OP_RD, 32'h60, '0);
        check_val("full_ready_low", bus.nat_request_ready, 0);
        bus.nat_request_valid = 1'b1;
        bus.nat_request_op    = OP_RD;
        bus.nat_request_addr  = 32'h0;
        for (int n = 0; n < 20 && !bus.nat_update_valid; n++) step();
        check_val("full_first_valid", bus.nat_update_valid, 1);
        check_val("ord0", bus.nat_update_data, d2);
        check_val("full_hold", bus.nat_request_ready, 0);
        bus.nat_update_ready = 1'b1;
        step();
        check_val("ready_after_pop", bus.nat_request_ready, 1);
        bus.nat_update_ready = 1'b0;
        step();
        bus.nat_request_valid = 1'b0;
        check_val("credit_stays_full", bus.nat_request_ready, 0);
        expect_update("ord1", d1);
        expect_update("ord2", d_a5);
        expect_update("ord3", d3);
        expect_update("ord4_held_rd", d2);
        check_val("drain_empty", bus.nat_update_valid, 0);
        check_val("drain_ready", bus.nat_request_ready, 1);

        // 5: illegal op
        issue(OP_IL, 32'h40, d_11);
        check_val("ill_pulse", bus.illegal_op, 1);
        step();
        check_val("ill_pulse_end", bus.illegal_op, 0);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.nat_update_valid) seen = 1'b1;
            step();
        end
        check_val("ill_no_upd", seen, 0);
        issue(OP_RD, 32'h40, '0);
        check_val("rd_no_ill", bus.illegal_op, 0);
        expect_update("ill_mem_kept", d_a5);

        // 6: reset with two reads in flight
        issue(OP_RD, 32'h20, '0);
        issue(OP_RD, 32'h60, '0);
        step();
        check_val("pre_rst_valid", bus.nat_update_valid, 0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check_val("midrst_valid", bus.nat_update_valid, 0);
        check_val("midrst_ready", bus.nat_request_ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.nat_update_valid) seen = 1'b1;
            step();
        end
        check_val("midrst_dropped", seen, 0);
        issue(OP_RD, 32'h40, '0);
        expect_update("mem_after_rst2", d_a5);
        issue(OP_RD, 32'h60, '0);
        expect_update("mem_after_rst3", d3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
